// File: rtl/bcd_scan_counter_pkg.sv
// Shared constants for the four-digit BCD scan counter.
package bcd_scan_counter_pkg;

  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam logic [3:0]  BLANK_CODE = 4'hF;
  localparam int unsigned DIGITS     = 4;
  localparam int unsigned IDX_W      = 2;

  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;

  function automatic logic [3:0] an_pattern(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    an_pattern = AN_D0;
      2'd1:    an_pattern = AN_D1;
      2'd2:    an_pattern = AN_D2;
      default: an_pattern = AN_D3;
    endcase
  endfunction

endpackage

// File: rtl/bcd_scan_counter_digit.sv
// One decade cell: 4-bit BCD register with load, up/down step and
// terminal flag (digit would carry or borrow if stepped).
module bcd_digit
  import bcd_scan_counter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       step_i,
  input  logic       up_i,
  input  logic       load_i,
  input  logic [3:0] load_nib_i,
  output logic       step_o,
  output logic [3:0] val_o
);

  logic [3:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = (load_nib_i > BCD_MAX) ? '0 : load_nib_i;
    end else if (step_i) begin
      if (up_i) val_d = (val_q == BCD_MAX) ? '0 : val_q + 4'd1;
      else      val_d = (val_q == '0) ? BCD_MAX : val_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) val_q <= '0;
    else       val_q <= val_d;
  end

  // Not gated by step_i; the top level ANDs this into the chain.
  assign step_o = up_i ? (val_q == BCD_MAX) : (val_q == '0);
  assign val_o  = val_q;

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with multiplexed 7-segment scan output
// and optional leading-zero blanking.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        blank,
  output logic [15:0] count,
  output logic        carry,
  output logic [3:0]  digit,
  output logic [3:0]  an
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIGITS:0]   step;
  logic [DIGITS-1:0] term;
  logic              carry_q, carry_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        an_q, an_d;

  assign step[0] = en & ~load;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_i      (clk),
      .rst_i      (rst),
      .step_i     (step[g]),
      .up_i       (up),
      .load_i     (load),
      .load_nib_i (load_val[4*g +: 4]),
      .step_o     (term[g]),
      .val_o      (count[4*g +: 4])
    );
    assign step[g+1] = step[g] & term[g];
  end

  always_comb begin
    carry_d = step[DIGITS];
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    idx_d   = (div_q == DIV_LAST) ? idx_q + IDX_W'(1) : idx_q;
    an_d    = an_pattern(idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      an_q    <= AN_D0;
    end else begin
      carry_q <= carry_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
    end
  end

  // Blank when the selected digit and every digit above it are zero.
  logic [3:0] sel_nib;
  logic       upper_zero;
  always_comb begin
    sel_nib    = count[{idx_q, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i >= 32'(idx_q) && count[4*i +: 4] != '0) upper_zero = 1'b0;
    end
    digit = (blank && idx_q != '0 && upper_zero) ? BLANK_CODE : sel_nib;
  end

  assign carry = carry_q;
  assign an    = an_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench: decimal reference model queues expected outputs per cycle,
// a negedge monitor pops and compares against the DUT.
module tb_bcd_scan_counter;

  localparam int SDIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0, blank = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] count;
  logic        carry;
  logic [3:0]  digit, an;

  bcd_scan_counter #(.SCAN_DIV(SDIV)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .blank(blank),
    .count(count), .carry(carry), .digit(digit), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] count;
    logic        carry;
    logic [3:0]  an;
    logic [3:0]  digit;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: plain decimal value and scan position.
  int m_val = 0, m_div = 0, m_idx = 0;
  bit m_car = 0;

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic int sanitize(input logic [15:0] lv);
    int v = 0;
    for (int k = 0; k < 4; k++) begin
      int n = int'(lv[4*k +: 4]);
      if (n > 9) n = 0;
      v = v + n * pow10(k);
    end
    return v;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_val = 0; m_car = 0; m_div = 0; m_idx = 0;
    end else begin
      if (m_div == SDIV - 1) begin
        m_div = 0; m_idx = (m_idx + 1) % 4;
      end else m_div = m_div + 1;
      if (load) begin
        m_val = sanitize(load_val); m_car = 0;
      end else if (en && up) begin
        m_car = (m_val == 9999); m_val = (m_val + 1) % 10000;
      end else if (en) begin
        m_car = (m_val == 0); m_val = (m_val + 9999) % 10000;
      end else m_car = 0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    logic [3:0] onehot;
    e.count = to_bcd(m_val);
    e.carry = m_car;
    onehot  = 4'(1 << m_idx);
    e.an    = ~onehot;
    if (blank && m_idx > 0 && m_val < pow10(m_idx)) e.digit = 4'hF;
    else e.digit = 4'((m_val / pow10(m_idx)) % 10);
    q.push_back(e);
  endtask

  // Inputs change at posedge+1; expected state for the current cycle is
  // queued with the new blank value, then the model advances on the edge.
  task automatic cyc(input bit r, input bit l, input bit e, input bit u,
                     input bit b, input logic [15:0] lv);
    rst = r; load = l; en = e; up = u; blank = b; load_val = lv;
    push_exp();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if ({count, carry, an, digit} !== e) begin
          n_err++;
          $display("FAIL scoreboard t=%0t got count=%h carry=%b an=%b digit=%h want count=%h carry=%b an=%b digit=%h",
                   $time, count, carry, an, digit, e.count, e.carry, e.an, e.digit);
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    cyc(1, 0, 0, 0, 0, 16'h0000);
    // Carry-chain through 0999 -> 1000
    cyc(0, 1, 0, 0, 0, 16'h0998);
    repeat (3) cyc(0, 0, 1, 1, 0, 16'h0000);
    // Wrap up
    cyc(0, 1, 0, 0, 0, 16'h9999);
    cyc(0, 0, 1, 1, 0, 16'h0000);
    cyc(0, 0, 0, 1, 0, 16'h0000);
    cyc(0, 0, 0, 1, 0, 16'h0000);
    // Wrap down, illegal nibble load
    cyc(0, 1, 0, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 0, 0, 0, 16'h0000);
    cyc(0, 1, 0, 0, 0, 16'h12A4);
    cyc(0, 0, 0, 0, 0, 16'h0000);
    // Priority: load over en, rst over load
    cyc(0, 1, 1, 1, 0, 16'h0500);
    cyc(0, 0, 0, 1, 0, 16'h0000);
    cyc(1, 1, 1, 1, 0, 16'h1234);
    // Scan and blanking from a fresh reset
    cyc(0, 1, 0, 0, 1, 16'h0042);
    repeat (16) cyc(0, 0, 0, 0, 1, 16'h0000);
    repeat (16) cyc(0, 0, 0, 0, 0, 16'h0000);
    // Reset mid-scan while counting
    repeat (9) cyc(0, 0, 1, 1, 1, 16'h0000);
    cyc(1, 0, 1, 1, 1, 16'h0000);
    repeat (10) cyc(0, 0, 0, 1, 1, 16'h0000);
    // Random traffic
    for (int k = 0; k < 600; k++) begin
      logic [15:0] lv;
      lv = 16'($urandom);
      if ($urandom_range(0, 2) == 0) lv = 16'h9990 | 16'($urandom_range(0, 9));
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), lv);
    end
    cyc(0, 0, 0, 0, 0, 16'h0000);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries never compared, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
